// File: rtl/keypad_loader.sv
// keypad_loader: keypad/button front end for the minutes:seconds countdown timer.
// Synchronizes and debounces the digit keys and the start/stop buttons, shifts
// accepted digits into the timer's serial load port and sequences run/pause/clear.
//
// Handshake: the timer samples data on every cycle that loadn is low (one-cycle
// strobe) and clears on every cycle that tclrn is low; there is no back-pressure,
// and loadn and tclrn are never low together.

// Generic debouncer: a code must be stable for DEBOUNCE consecutive samples to be
// accepted. A non-zero code is reported once, as a one-cycle echo on press_o, and
// the debouncer then stays locked until all-zero has been stable for DEBOUNCE
// samples. It comes out of reset locked, so a code already held at reset must be
// released before it can be accepted.
module keypad_debounce #(
  parameter int W        = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic         clock,
  input  logic         clrn,
  input  logic [W-1:0] code_i,
  output logic [W-1:0] press_o
);

  logic [W-1:0] cand_q, cand_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         lock_q, lock_d;
  logic         same;
  logic         settle;

  // Stability counter: restart on any change, saturate once settled.
  always_comb begin
    same    = (code_i == cand_q);
    settle  = same && (cnt_q == 8'(DEBOUNCE - 1));
    cand_d  = code_i;
    if (!same) begin
      cnt_d = 8'd1;
    end else if (cnt_q != 8'(DEBOUNCE)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    lock_d = lock_q;
    if (settle) begin
      lock_d = (cand_q != '0);
    end
    press_o = (settle && !lock_q) ? cand_q : '0;
  end

  // Debounce state registers.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cand_q <= '0;
      cnt_q  <= 8'd0;
      lock_q <= 1'b1;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

endmodule

module keypad_loader #(
  parameter int DEBOUNCE   = 4,
  parameter int MAX_DIGITS = 3
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       zero,
  output logic [3:0] data,
  output logic       loadn,
  output logic       tclrn,
  output logic       en,
  output logic [1:0] digits,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_RUNNING = 2'd2,
    S_PAUSED  = 2'd3
  } state_t;

  logic [9:0] key_s1_q, key_s2_q;
  logic [1:0] btn_s1_q, btn_s2_q;   // bit 0 = start pressed, bit 1 = stop pressed

  logic [3:0] key_hits;
  logic [3:0] key_idx;
  logic [3:0] key_code;             // 0 = no valid key, k+1 = digit k
  logic [3:0] key_press;
  logic       start_ev;
  logic       stop_ev;
  logic       digit_ev;
  logic [3:0] key_digit;

  state_t     state_q, state_d;
  logic [3:0] data_q, data_d;
  logic       loadn_q, loadn_d;
  logic       tclrn_q, tclrn_d;
  logic [1:0] digits_q, digits_d;

  // Two-flop synchronizers; buttons are inverted so 1 means pressed.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      key_s1_q <= keypad;
      key_s2_q <= key_s1_q;
      btn_s1_q <= {~stopn, ~startn};
      btn_s2_q <= btn_s1_q;
    end
  end

  // One-hot check: anything other than exactly one key reads as no key.
  always_comb begin
    key_hits = 4'd0;
    key_idx  = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (key_s2_q[k]) begin
        key_hits = key_hits + 4'd1;
        key_idx  = 4'(k);
      end
    end
    key_code = (key_hits == 4'd1) ? key_idx + 4'd1 : 4'd0;
  end

  keypad_debounce #(.W(4), .DEBOUNCE(DEBOUNCE)) u_key_db (
    .clock   (clock),
    .clrn    (clrn),
    .code_i  (key_code),
    .press_o (key_press)
  );

  keypad_debounce #(.W(1), .DEBOUNCE(DEBOUNCE)) u_start_db (
    .clock   (clock),
    .clrn    (clrn),
    .code_i  (btn_s2_q[0]),
    .press_o (start_ev)
  );

  keypad_debounce #(.W(1), .DEBOUNCE(DEBOUNCE)) u_stop_db (
    .clock   (clock),
    .clrn    (clrn),
    .code_i  (btn_s2_q[1]),
    .press_o (stop_ev)
  );

  assign digit_ev  = (key_press != 4'd0);
  assign key_digit = key_press - 4'd1;

  // Next-state logic; within a cycle stop beats start beats digit.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    digits_d = digits_q;
    loadn_d  = 1'b1;
    tclrn_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (stop_ev) begin
          tclrn_d = 1'b0;
          data_d  = 4'd0;
        end else if (start_ev) begin
          state_d = S_IDLE;
        end else if (digit_ev) begin
          loadn_d  = 1'b0;
          data_d   = key_digit;
          digits_d = 2'd1;
          state_d  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (stop_ev) begin
          tclrn_d  = 1'b0;
          data_d   = 4'd0;
          digits_d = 2'd0;
          state_d  = S_IDLE;
        end else if (start_ev) begin
          state_d = S_RUNNING;
        end else if (digit_ev && (digits_q < 2'(MAX_DIGITS))) begin
          loadn_d  = 1'b0;
          data_d   = key_digit;
          digits_d = digits_q + 2'd1;
        end
      end
      S_RUNNING: begin
        // The timer reaching zero ends the run even if stop arrives too.
        if (zero) begin
          digits_d = 2'd0;
          state_d  = S_IDLE;
        end else if (stop_ev) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (stop_ev) begin
          tclrn_d  = 1'b0;
          data_d   = 4'd0;
          digits_d = 2'd0;
          state_d  = S_IDLE;
        end else if (start_ev) begin
          state_d = S_RUNNING;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered timer-side outputs.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      data_q   <= 4'd0;
      loadn_q  <= 1'b1;
      tclrn_q  <= 1'b1;
      digits_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      loadn_q  <= loadn_d;
      tclrn_q  <= tclrn_d;
      digits_q <= digits_d;
    end
  end

  assign data      = data_q;
  assign loadn     = loadn_q;
  assign tclrn     = tclrn_q;
  assign digits    = digits_q;
  assign state_dbg = state_q;
  // Enable drops in the same cycle zero rises so the timer never wraps past 0:00.
  assign en        = (state_q == S_RUNNING) && !zero;

endmodule
